// File: rtl/cc_bus_sequencer.sv
// Beat-by-beat requester for the cc select/gate network: strobes the network, waits for
// settle and ack, gathers BEATS samples into one response word behind a valid/ready handshake.
module cc_bus_sequencer #(
   parameter int DATA_W  = 8,
   parameter int BEATS   = 4,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_mode,
   output logic                      bus_i,
   output logic                      bus_k,
   output logic                      bus_m,
   output logic                      bus_p,
   output logic                      bus_q,
   input  logic                      bus_ack,
   input  logic [DATA_W-1:0]         bus_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W*BEATS-1:0]   rsp_data,
   output logic                      rsp_err
);

   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_WAIT_ACK,
      S_SAMPLE,
      S_RESP
   } state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [SW-1:0]             settle_q, settle_d;
   logic [WW-1:0]             wait_q, wait_d;
   logic                      sep_q, sep_d;
   logic                      p_q, p_d;
   logic                      q_q, q_d;
   logic [DATA_W*BEATS-1:0]   data_q, data_d;
   logic                      err_q, err_d;
   logic                      advance;
   logic                      busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         beat_q   <= '0;
         settle_q <= '0;
         wait_q   <= '0;
         sep_q    <= 1'b0;
         p_q      <= 1'b0;
         q_q      <= 1'b0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         settle_q <= settle_d;
         wait_q   <= wait_d;
         sep_q    <= sep_d;
         p_q      <= p_d;
         q_q      <= q_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      settle_d = settle_q;
      wait_d   = wait_q;
      sep_d    = sep_q;
      p_d      = p_q;
      q_d      = q_q;
      data_d   = data_q;
      err_d    = err_q;
      advance  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               p_d      = req_mode[1];
               q_d      = req_mode[0];
               data_d   = '0;
               err_d    = 1'b0;
               beat_d   = '0;
               settle_d = '0;
               wait_d   = '0;
               sep_d    = 1'b0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // The separator cycle (bus_i low) does not count as settling time.
            // Ack is checked on the last settle cycle, so an early ack costs no wait cycle.
            if (sep_q) begin
               sep_d = 1'b0;
            end else if (settle_q == SW'(SETTLE - 1)) begin
               settle_d = '0;
               wait_d   = '0;
               state_d  = bus_ack ? S_SAMPLE : S_WAIT_ACK;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (bus_ack) begin
               state_d = S_SAMPLE;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
               err_d = 1'b1;
               data_d[int'(beat_q)*DATA_W +: DATA_W] = '0;
               advance = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            data_d[int'(beat_q)*DATA_W +: DATA_W] = bus_data;
            advance = 1'b1;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         wait_d = '0;
         if (beat_q == BW'(BEATS - 1)) begin
            state_d = S_RESP;
         end else begin
            beat_d  = beat_q + 1'b1;
            sep_d   = 1'b1;
            state_d = S_SETTLE;
         end
      end
   end

   assign busy      = (state_q == S_SETTLE) || (state_q == S_WAIT_ACK) || (state_q == S_SAMPLE);
   assign bus_k     = busy;
   assign bus_m     = busy;
   assign bus_i     = busy & ~sep_q;
   assign bus_p     = busy & p_q;
   assign bus_q     = busy & q_q;
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_cc_bus_sequencer.sv
// Bench for cc_bus_sequencer: models the network (ack/data per beat) and predicts
// response word, error flag and latency from per-beat ack delays.
module tb_cc_bus_sequencer;

   localparam int DATA_W  = 8;
   localparam int BEATS   = 4;
   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 15;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     req_valid;
   logic                     req_ready;
   logic [1:0]               req_mode;
   logic                     bus_i, bus_k, bus_m, bus_p, bus_q;
   logic                     bus_ack;
   logic [DATA_W-1:0]        bus_data;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [DATA_W*BEATS-1:0]  rsp_data;
   logic                     rsp_err;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] bdata [BEATS];
   int                bdly  [BEATS];   // ack delay per beat; -1 = never acks
   int                beat;
   int                cyc;
   logic              prev_i;

   cc_bus_sequencer #(
      .DATA_W (DATA_W),
      .BEATS  (BEATS),
      .SETTLE (SETTLE),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_mode (req_mode),
      .bus_i    (bus_i),
      .bus_k    (bus_k),
      .bus_m    (bus_m),
      .bus_p    (bus_p),
      .bus_q    (bus_q),
      .bus_ack  (bus_ack),
      .bus_data (bus_data),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Network model: data for the current beat, ack once the beat's delay has elapsed.
   task automatic drive_net();
      bus_ack  = 1'b0;
      bus_data = DATA_W'($urandom);
      if (beat >= 0 && beat < BEATS) begin
         bus_data = bdata[beat];
         if (bus_i === 1'b1 && bdly[beat] >= 0 && cyc >= SETTLE - 1 + bdly[beat])
            bus_ack = 1'b1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive_net();
      @(posedge clk);
      #1;
      if (bus_i === 1'b1 && prev_i !== 1'b1) begin
         beat++;
         cyc = 0;
      end else if (bus_i === 1'b1) begin
         cyc++;
      end
      prev_i = bus_i;
   endtask

   task automatic run_txn(input logic [1:0] mode, input int hold);
      logic [DATA_W*BEATS-1:0] exp_data;
      logic [DATA_W*BEATS-1:0] held;
      logic                    exp_err;
      int                      exp_lat, lat, lows, run;
      bit                      ok;
      exp_data = '0;
      exp_err  = 1'b0;
      exp_lat  = BEATS - 1;
      for (int n = 0; n < BEATS; n++) begin
         ok = (bdly[n] >= 0) && (bdly[n] <= TIMEOUT);
         if (ok) begin
            exp_data[n*DATA_W +: DATA_W] = bdata[n];
            exp_lat += SETTLE + bdly[n] + 1;
         end else begin
            exp_err = 1'b1;
            exp_lat += SETTLE + TIMEOUT;
         end
      end
      beat = -1; cyc = 0; prev_i = 1'b0;
      chk("idle_ready", req_ready, 1);
      req_mode  = mode;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      step();
      chk("accept", {req_ready, bus_i, bus_k, bus_m, bus_p, bus_q}, {1'b0, 1'b1, 1'b1, 1'b1, mode});
      lat = 0; lows = 0; run = 0;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         req_valid = 1'($urandom_range(0, 1));
         chk("strobes", {req_ready, bus_k, bus_m, bus_p, bus_q}, {1'b0, 1'b1, 1'b1, mode});
         if (bus_i !== 1'b1) begin
            lows++;
            run++;
            chk("sep_single", 64'(run > 1), 0);
         end else begin
            run = 0;
         end
         step();
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("sep_count", lows, BEATS - 1);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, exp_err);
      chk("resp_bus_idle", {bus_i, bus_k, bus_m, bus_p, bus_q}, 0);
      held = rsp_data;
      repeat (hold) begin
         req_valid = 1'($urandom_range(0, 1));
         step();
         chk("hold", {rsp_valid, req_ready, rsp_data, rsp_err}, {1'b1, 1'b0, exp_data, exp_err});
         chk("hold_stable", rsp_data, held);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("release", {rsp_valid, req_ready}, 2'b01);
   endtask

   initial begin
      int  guard;
      bit  seen;
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_mode = 2'b00;
      bus_ack = 1'b0; bus_data = '0; beat = -1; cyc = 0; prev_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {req_ready, rsp_valid, rsp_err, bus_i, bus_k, bus_m, bus_p, bus_q}, 8'b1000_0000);
      chk("reset_data", rsp_data, 0);
      @(negedge clk) rst_n = 1'b1;

      // Mode 01, ack immediate: 15-cycle latency.
      bdata = '{8'h11, 8'h22, 8'h33, 8'h44};
      bdly  = '{0, 0, 0, 0};
      run_txn(2'b01, 0);

      // Beat 1 never acks.
      bdly = '{0, -1, 0, 0};
      run_txn(2'b01, 0);

      // Long back-pressure.
      bdata = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
      bdly  = '{1, 0, 3, 0};
      run_txn(2'b00, 10);

      // Back-to-back, different modes.
      bdly = '{0, 2, 0, 1};
      run_txn(2'b10, 0);
      bdly = '{0, 0, 0, 0};
      run_txn(2'b11, 0);

      // Ack on the last permitted wait cycle still succeeds.
      bdata = '{8'h01, 8'h02, 8'h03, 8'h04};
      bdly  = '{0, 0, TIMEOUT, 0};
      run_txn(2'b10, 1);

      // Reset while waiting for ack on beat 2.
      bdata = '{8'h11, 8'h22, 8'h33, 8'h44};
      bdly  = '{0, 0, -1, 0};
      beat = -1; cyc = 0; prev_i = 1'b0;
      req_mode = 2'b11; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      guard = 0;
      while (!(beat == 2 && cyc == SETTLE + 3) && guard < 100) begin
         step();
         guard++;
      end
      chk("reach_beat2_wait", 64'(guard < 100), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_ctrl", {req_ready, rsp_valid, rsp_err, bus_i, bus_k, bus_m, bus_p, bus_q}, 8'b1000_0000);
      chk("rst_async_data", rsp_data, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         step();
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      chk("no_rsp_after_rst", seen, 0);
      chk("ready_after_rst", req_ready, 1);

      // Randomized transactions.
      for (int t = 0; t < 12; t++) begin
         int r;
         for (int n = 0; n < BEATS; n++) begin
            bdata[n] = DATA_W'($urandom);
            r = $urandom_range(0, 7);
            bdly[n] = (r == 7) ? -1 : r;
         end
         run_txn(2'($urandom_range(0, 3)), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
